// File: rtl/memory_port_arbiter.sv
// Shared image-RAM arbiter for camera, HPS reader, line-buffer loader and convolution write-back.
// Define MEMORY_PORT_ARBITER_RR_EN for round-robin among hps/buf/cnv; default is fixed hps > buf > cnv.
module memory_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 1023
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cam_req_i,
  input  logic              cam_we_i,
  input  logic [ADDR_W-1:0] cam_addr_i,
  input  logic [DATA_W-1:0] cam_wdata_i,
  output logic              cam_gnt_o,
  input  logic              hps_req_i,
  input  logic [ADDR_W-1:0] hps_addr_i,
  output logic              hps_gnt_o,
  output logic              hps_rvalid_o,
  input  logic              buf_req_i,
  input  logic              buf_lock_i,
  input  logic [ADDR_W-1:0] buf_addr_i,
  output logic              buf_gnt_o,
  output logic              buf_rvalid_o,
  input  logic              cnv_req_i,
  input  logic [ADDR_W-1:0] cnv_addr_i,
  input  logic [DATA_W-1:0] cnv_wdata_i,
  output logic              cnv_gnt_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        owner_o,
  output logic              starve_o
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              lock_act;
  logic              cam_gnt;
  logic              any_gnt;
  logic [2:0]        nc_req;    // bit 0 hps, bit 1 buf, bit 2 cnv
  logic [2:0]        nc_gnt;
  logic [2:0]        pri_gnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        owner_q, owner_d;
  logic              hps_rvalid_q, buf_rvalid_q;
  logic [CNT_W-1:0]  wait_q [3];
  logic              starve_c;

  assign nc_req   = {cnv_req_i, buf_req_i, hps_req_i};
  assign lock_act = (state_q == ST_LOCKED) && buf_lock_i;

`ifdef MEMORY_PORT_ARBITER_RR_EN
  logic [1:0] rr_q;

  // Round-robin pick starting at rr_q
  always_comb begin
    pri_gnt = '0;
    case (rr_q)
      2'd1: begin
        if (nc_req[1])      pri_gnt[1] = 1'b1;
        else if (nc_req[2]) pri_gnt[2] = 1'b1;
        else if (nc_req[0]) pri_gnt[0] = 1'b1;
      end
      2'd2: begin
        if (nc_req[2])      pri_gnt[2] = 1'b1;
        else if (nc_req[0]) pri_gnt[0] = 1'b1;
        else if (nc_req[1]) pri_gnt[1] = 1'b1;
      end
      default: begin
        if (nc_req[0])      pri_gnt[0] = 1'b1;
        else if (nc_req[1]) pri_gnt[1] = 1'b1;
        else if (nc_req[2]) pri_gnt[2] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q <= 2'd0;
    end else if (|nc_gnt) begin
      rr_q <= nc_gnt[0] ? 2'd1 : (nc_gnt[1] ? 2'd2 : 2'd0);
    end
  end
`else
  always_comb begin
    pri_gnt = '0;
    if (nc_req[0])      pri_gnt[0] = 1'b1;
    else if (nc_req[1]) pri_gnt[1] = 1'b1;
    else if (nc_req[2]) pri_gnt[2] = 1'b1;
  end
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: a locked buf grant opens a burst that lasts while buf_lock stays high
  always_comb begin
    state_d = ST_IDLE;
    if (nc_gnt[1] && buf_lock_i) state_d = ST_LOCKED;
    else if (lock_act)           state_d = ST_LOCKED;
    else if (any_gnt)            state_d = ST_GRANT;
  end

  // Grant decode: camera always wins, a live burst shuts out hps and cnv
  always_comb begin
    cam_gnt = 1'b0;
    nc_gnt  = '0;
    if (!reset_i) begin
      if (cam_req_i)     cam_gnt = 1'b1;
      else if (lock_act) nc_gnt  = {1'b0, buf_req_i, 1'b0};
      else               nc_gnt  = pri_gnt;
    end
    any_gnt = cam_gnt | (|nc_gnt);
  end

  // RAM command mux; address and owner hold through idle cycles
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_we_o = 1'b0;
    owner_d  = owner_q;
    if (cam_gnt) begin
      addr_d   = cam_addr_i;
      wdata_d  = cam_wdata_i;
      mem_we_o = cam_we_i;
      owner_d  = 2'd0;
    end else if (nc_gnt[0]) begin
      addr_d  = hps_addr_i;
      owner_d = 2'd1;
    end else if (nc_gnt[1]) begin
      addr_d  = buf_addr_i;
      owner_d = 2'd2;
    end else if (nc_gnt[2]) begin
      addr_d   = cnv_addr_i;
      wdata_d  = cnv_wdata_i;
      mem_we_o = 1'b1;
      owner_d  = 2'd3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 2'd0;
      hps_rvalid_q <= 1'b0;
      buf_rvalid_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      hps_rvalid_q <= nc_gnt[0];
      buf_rvalid_q <= nc_gnt[1];
    end
  end

  // Saturating wait counters for hps, buf, cnv
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 3; i++) begin
      if (reset_i || !nc_req[i] || nc_gnt[i]) wait_q[i] <= '0;
      else if (wait_q[i] != CNT_MAX)          wait_q[i] <= wait_q[i] + CNT_W'(1);
    end
  end

  always_comb begin
    starve_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (wait_q[i] == CNT_MAX) starve_c = 1'b1;
    end
  end

  assign cam_gnt_o    = cam_gnt;
  assign hps_gnt_o    = nc_gnt[0];
  assign buf_gnt_o    = nc_gnt[1];
  assign cnv_gnt_o    = nc_gnt[2];
  assign mem_addr_o   = addr_d;
  assign mem_wdata_o  = wdata_d;
  assign hps_rvalid_o = hps_rvalid_q & ~reset_i;
  assign buf_rvalid_o = buf_rvalid_q & ~reset_i;
  assign rdata_o      = mem_rdata_i;
  assign owner_o      = reset_i ? 2'd0 : owner_d;
  assign starve_o     = starve_c & ~reset_i;

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning image memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning image memory word width.
REQ-003 SHALL have parameter STARVE_MAX, default 1023, meaning the wait-cycle threshold for the starvation flag.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have ports cam_req/cam_we (input, 1), cam_addr (input, ADDR_W), cam_wdata (input, DATA_W) and cam_gnt (output, 1), meaning the camera port, synchronous to clk.
REQ-007 SHALL have ports hps_req (input, 1), hps_addr (input, ADDR_W), hps_gnt (output, 1) and hps_rvalid (output, 1), meaning the HPS image-read port.
REQ-008 SHALL have ports buf_req/buf_lock (input, 1), buf_addr (input, ADDR_W), buf_gnt (output, 1) and buf_rvalid (output, 1), meaning the line-buffer row-load port.
REQ-009 SHALL have ports cnv_req (input, 1), cnv_addr (input, ADDR_W), cnv_wdata (input, DATA_W) and cnv_gnt (output, 1), meaning the convolution write-back port, which is write-only.
REQ-010 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, DATA_W) and mem_we (output, 1), meaning the shared RAM command.
REQ-011 SHALL have ports mem_rdata (input, DATA_W), rdata (output, DATA_W), owner (output, 2; 0=cam, 1=hps, 2=buf, 3=cnv) and starve (output, 1).

Function
REQ-012 SHALL issue at most one grant per cycle; grants are combinational from the current-cycle req, and mem_addr/mem_wdata/mem_we are driven from the granted port in that same cycle.
REQ-013 SHALL always grant cam_req first.
REQ-014 SHALL drive mem_we as cam_we on a camera grant, 1 on a cnv grant, and 0 otherwise.
REQ-015 SHALL assert hps_rvalid or buf_rvalid exactly one cycle after the corresponding read grant, with rdata equal to mem_rdata in that cycle.
REQ-016 SHALL support back-to-back grants every cycle; a requester updates its addr or drops req on the edge ending its gnt cycle.
REQ-017 SHALL use FSM states IDLE (no grant), GRANT (single-word grant issued) and LOCKED (buf burst).
REQ-018 SHALL enter LOCKED when buf is granted with buf_lock=1, and SHALL stay in LOCKED while buf_lock=1.
REQ-019 SHALL, in LOCKED, deny hps and cnv; cam still preempts, and buf_gnt drops only for that cycle.
REQ-020 SHALL leave LOCKED to IDLE/GRANT on the first cycle with buf_lock=0.
REQ-021 SHALL assign non-camera priority per the Configuration section.
REQ-022 SHALL keep a per-port wait counter for hps, buf and cnv: it increments while req=1 and gnt=0, clears on gnt or req=0, and saturates at STARVE_MAX.
REQ-023 SHALL assert starve while any wait counter equals STARVE_MAX, and SHALL clear starve when no counter is at STARVE_MAX.
REQ-024 SHALL hold owner at the last granted port, unchanged in idle cycles.
REQ-025 SHALL, with no requests, hold mem_we=0 and mem_addr at its last value.

Reset
REQ-026 SHALL, while reset=1, drive all gnt, rvalid, mem_we and starve to 0 and owner to 0, set state to IDLE, and clear the pointer and counters.
REQ-027 SHALL, on reset during LOCKED or with a read in flight, suppress the pending rvalid and issue no grant in the reset cycle.

Configuration
REQ-028 SHALL, with macro MEMORY_PORT_ARBITER_RR_EN defined, rotate priority round-robin among hps/buf/cnv, with the pointer advancing to one past the last non-camera grantee.
REQ-029 SHALL, without MEMORY_PORT_ARBITER_RR_EN, use fixed priority hps > buf > cnv, with no pointer register.

Verification
REQ-030 SHALL verify: cam_req=1 cam_we=1 with hps_req=1 in the same cycle -> cam_gnt=1, mem_we=1, hps_gnt=0; next cycle hps_gnt=1 once cam_req=0.
REQ-031 SHALL verify: hps_req with hps_addr=0x0123 and mem_rdata=0xDEADBEEF -> hps_gnt cycle k, mem_addr=0x0123, then hps_rvalid=1 and rdata=0xDEADBEEF at k+1.
REQ-032 SHALL verify: buf_lock=1 for 128 grants with cnv_req=1 -> cnv_gnt=0 throughout, and cnv_gnt=1 on the first cycle after buf_lock=0.
REQ-033 SHALL verify: RR_EN defined with hps/buf/cnv all requesting for 6 cycles -> grant order hps,buf,cnv,hps,buf,cnv; RR_EN undefined -> hps on all 6.
REQ-034 SHALL verify: STARVE_MAX=7, cam_req held high with cnv_req=1 -> starve=1 after 7 waiting cycles, and starve=0 the cycle after cnv_gnt.
REQ-035 SHALL verify: reset asserted in LOCKED with a buf read in flight -> buf_rvalid=0 and all gnt=0 next cycle, state IDLE.
